psram_spi_initiator: RTL

FPGA-side single-bit SPI initiator for the board's serial PSRAM. It owns the `ram_cs`/`ram_sck`/`ram_data*` pins that the ESP32 drives in passthrough builds. It turns command-level read/write bursts from fabric logic into PSRAM slow-read (0x03) and write (0x02) transactions, using SPI mode 0 with MSB first. Byte-stream handshakes sit on the fabric side.

---
 rtl/psram_spi_initiator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/psram_spi_initiator.sv
// rtl/psram_spi_initiator.sv - single-bit SPI mode-0 initiator for serial PSRAM read/write bursts
module psram_spi_initiator #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        ram_cs,
  output logic        ram_sck,
  output logic        ram_data0,
  input  logic        ram_data1,
  output logic        ram_data2,
  output logic        ram_data3
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  // div_cnt is wide enough to time the 2*CLK_DIV chip-select gap
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  logic [2:0]  state;
  logic [8:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  // Bit 7 of the current outgoing word lives in mosi_q, so only 31 bits need shifting;
  // sampled MISO bits enter at the bottom and the low 7 bits form the read byte.
  logic [30:0] shift_q;
  logic        is_write;
  logic        cs_q;
  logic        sck_q;
  logic        mosi_q;
  logic [7:0]  opcode;
  logic        half_done;
  logic        bit_done;

  assign opcode    = cmd_write ? 8'h02 : 8'h03;
  assign half_done = (div_cnt == HALF_LAST);
  // A bit cell ends on the edge that takes sck from high back to low
  assign bit_done  = half_done && sck_q;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign wr_ready  = (state == S_WAIT_WR);
  assign ram_cs    = cs_q;
  assign ram_sck   = sck_q;
  assign ram_data0 = mosi_q;
  assign ram_data2 = 1'b1;
  assign ram_data3 = 1'b1;

  // Transaction sequencer: bit-cell timing, shifting, byte counting and cs framing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift_q  <= '0;
      is_write <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            is_write <= cmd_write;
            byte_cnt <= cmd_len;
            shift_q  <= {opcode[6:0], cmd_addr};
            mosi_q   <= opcode[7];
            cs_q     <= 1'b0;
            sck_q    <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= S_CMD;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (half_done) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
          if (bit_done) begin
            shift_q <= {shift_q[29:0], ram_data1};
            bit_cnt <= bit_cnt + 5'd1;
            // MOSI is idle-low while reading data bytes
            mosi_q  <= (state == S_DATA && !is_write) ? 1'b0 : shift_q[30];
            if (state == S_CMD && bit_cnt == 5'd7) begin
              state <= S_ADDR;
            end
            if (state == S_ADDR && bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              mosi_q  <= 1'b0;
              state   <= is_write ? S_WAIT_WR : S_DATA;
            end
            if (state == S_DATA && bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt - 8'd1;
              if (!is_write) begin
                rd_data  <= {shift_q[6:0], ram_data1};
                rd_valid <= 1'b1;
              end
              if (byte_cnt == 8'd0) begin
                mosi_q <= 1'b0;
                state  <= S_END;
              end else if (is_write) begin
                mosi_q <= 1'b0;
                state  <= S_WAIT_WR;
              end
            end
          end
        end

        S_WAIT_WR: begin
          // sck is parked low here, so a late byte simply stretches the transaction
          if (wr_valid) begin
            shift_q[30:24] <= wr_data[6:0];
            mosi_q         <= wr_data[7];
            div_cnt        <= '0;
            state          <= S_DATA;
          end
        end

        S_END: begin
          if (half_done) begin
            cs_q    <= 1'b1;
            div_cnt <= '0;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        S_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
